// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock,
// with valid/ready on both sides and a per-state bypass for the final round.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_skip,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 sits in the most significant byte of a column word.
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;
    {a0, a1, a2, a3} = a;
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
    return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
            a0 ^ x1 ^ x2 ^ a2 ^ a3,
            a0 ^ a1 ^ x2 ^ x3 ^ a3,
            x0 ^ a0 ^ a1 ^ a2 ^ x3};
  endfunction

  logic [1:0]   state_reg, state_next;
  logic [1:0]   cnt_reg, cnt_next;
  logic [127:0] work_reg, work_next;
  logic [127:0] out_data_reg, out_data_next;
  logic [127:0] work_upd;
  logic         load;

  logic [31:0] col     [4];
  logic [31:0] col_upd [4];
  logic [31:0] mixed   [COLS_PER_CYCLE];

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign col[gi] = work_reg[127-32*gi -: 32];
    assign work_upd[127-32*gi -: 32] = col_upd[gi];
  end

  // Only COLS_PER_CYCLE mixers exist; the counter steers which columns feed them.
  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_mix
    assign mixed[gi] = mix_col(col[cnt_reg + 2'(gi)]);
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      col_upd[c] = col[c];
    end
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_upd[cnt_reg + 2'(j)] = mixed[j];
    end
  end

  assign in_ready  = !rst && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign out_valid = (state_reg == DONE);
  assign out_data  = out_data_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    work_next     = work_reg;
    out_data_next = out_data_reg;
    load          = 1'b0;
    case (state_reg)
      IDLE: load = in_valid;
      BUSY: begin
        work_next = work_upd;
        cnt_next  = cnt_reg + STEP;
        if (cnt_reg == LAST) begin
          state_next    = DONE;
          out_data_next = work_upd;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // A new state may arrive from IDLE or, back-to-back, from DONE.
    if (load) begin
      work_next = in_data;
      cnt_next  = '0;
      if (in_skip) begin
        state_next    = DONE;
        out_data_next = in_data;
      end else begin
        state_next = BUSY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      work_reg     <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      work_reg     <= work_next;
      out_data_reg <= out_data_next;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: one lane per COLS_PER_CYCLE value (1, 2, 4), each with
// directed vectors, backpressure, mid-operation reset and a scoreboarded random run.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] kin  [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101,
                            32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
  logic [31:0] kout [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101,
                            32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s %s", name, detail);
  endtask

  // GF(2^8) multiply by shift-and-add, reduced mod 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s, input bit skip);
    logic [7:0] coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0] st [4][4];
    logic [7:0] o;
    logic [127:0] res = '0;
    if (skip) return s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = s[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o = 8'h00;
        for (int k = 0; k < 4; k++) o ^= gmul(coef[(k - r + 4) % 4], st[k][c]);
        res[127-8*(4*c+r) -: 8] = o;
      end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    localparam int C   = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    localparam int LAT = 4 / C + 1;

    logic         rst, in_valid, in_ready, in_skip, out_valid, out_ready;
    logic [127:0] in_data, out_data;
    logic [127:0] exp_q [$];
    int           n_in = 0;
    int           n_out = 0;
    bit           rand_done = 0;
    bit           finished = 0;

    mix_columns_seq #(.COLS_PER_CYCLE(C)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_skip   (in_skip),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
    );

    // Monitor: every transfer on the output side pops one expectation.
    always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
        n_out++;
        $display("c%0d out %0d data=%h", C, n_out, out_data);
        if (exp_q.size() == 0)
          fail($sformatf("c%0d_unexpected_output", C),
               $sformatf("act=%h exp=<no pending state>", out_data));
        else
          chk($sformatf("c%0d_out_data", C), out_data, exp_q.pop_front());
      end
    end

    task automatic send(input logic [127:0] d, input bit sk, input logic [127:0] e,
                        output int waits);
      in_data  = d;
      in_skip  = sk;
      in_valid = 1'b1;
      waits    = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        if (waits >= 300) begin
          fail($sformatf("c%0d_accept_timeout", C), "act=no in_ready exp=accept");
          in_valid = 1'b0;
          return;
        end
        waits++;
        @(posedge clk); #1;
      end
      exp_q.push_back(e);
      n_in++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = rnd128();
      in_skip  = 1'($urandom);
    endtask

    task automatic wait_out(output int lat);
      lat = 1;
      forever begin
        @(negedge clk);
        if (out_valid) break;
        if (lat >= 40) begin
          fail($sformatf("c%0d_out_timeout", C), "act=no out_valid exp=out_valid");
          break;
        end
        lat++;
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    endtask

    task automatic xact(input string name, input logic [127:0] d, input bit sk,
                        input logic [127:0] e, input int exp_lat);
      int w, lat;
      send(d, sk, e, w);
      wait_out(lat);
      chk($sformatf("c%0d_%s_latency", C, name), 128'(lat), 128'(exp_lat));
      repeat (2) @(posedge clk);
      #1;
    endtask

    initial begin
      logic [127:0] a, held;
      int w, lat, pos;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_skip = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk($sformatf("c%0d_rst_in_ready", C), 128'(in_ready), 128'(0));
      chk($sformatf("c%0d_rst_out_valid", C), 128'(out_valid), 128'(0));
      chk($sformatf("c%0d_rst_out_data", C), out_data, 128'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk($sformatf("c%0d_post_rst_in_ready", C), 128'(in_ready), 128'(1));
      @(posedge clk); #1;

      xact("fips", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
           128'h046681e5e0cb199a48f8d37a2806264c, LAT);

      for (int i = 0; i < 6; i++) begin
        pos = i % 4;
        xact($sformatf("col%0d", i), 128'(kin[i]) << (96 - 32 * pos), 1'b0,
             128'(kout[i]) << (96 - 32 * pos), LAT);
      end

      xact("skip", 128'h00112233445566778899aabbccddeeff, 1'b1,
           128'h00112233445566778899aabbccddeeff, 1);

      // Backpressure, then release with a new state in the same cycle.
      out_ready = 1'b0;
      a = rnd128();
      send(a, 1'b0, ref_state(a, 1'b0), w);
      wait_out(lat);
      @(negedge clk);
      held = out_data;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk($sformatf("c%0d_bp_valid", C), 128'(out_valid), 128'(1));
        chk($sformatf("c%0d_bp_stable", C), out_data, held);
        chk($sformatf("c%0d_bp_in_ready", C), 128'(in_ready), 128'(0));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      a = rnd128();
      send(a, 1'b0, ref_state(a, 1'b0), w);
      chk($sformatf("c%0d_bp_release_accept_wait", C), 128'(w), 128'(0));
      wait_out(lat);
      chk($sformatf("c%0d_bp_second_latency", C), 128'(lat), 128'(LAT));
      repeat (2) @(posedge clk);
      #1;

      // Reset while BUSY (counter at 2 where the column count allows).
      a = rnd128();
      send(a, 1'b0, ref_state(a, 1'b0), w);
      repeat (2 / C) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(exp_q.pop_back());
      n_in--;
      @(negedge clk);
      chk($sformatf("c%0d_midrst_out_valid", C), 128'(out_valid), 128'(0));
      chk($sformatf("c%0d_midrst_out_data", C), out_data, 128'h0);
      chk($sformatf("c%0d_midrst_in_ready", C), 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      a = rnd128();
      xact("after_rst", a, 1'b0, ref_state(a, 1'b0), LAT);

      // Random regression with input gaps and output stalls.
      fork
        begin
          while (!rand_done) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
          end
          out_ready = 1'b1;
        end
        begin
          logic [127:0] d;
          bit sk;
          int ww;
          for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk); #1;
            end
            d  = rnd128();
            sk = ($urandom_range(0, 3) == 0);
            send(d, sk, ref_state(d, sk), ww);
          end
          rand_done = 1;
        end
      join

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk($sformatf("c%0d_drain_pending", C), 128'(exp_q.size()), 128'(0));
      chk($sformatf("c%0d_out_count", C), 128'(n_out), 128'(n_in));
      finished = 1;
    end
  end

  initial begin
    for (int i = 0; i < 80000; i++) begin
      if (g_lane[0].finished && g_lane[1].finished && g_lane[2].finished) break;
      @(posedge clk);
    end
    if (!(g_lane[0].finished && g_lane[1].finished && g_lane[2].finished))
      fail("watchdog", "act=lanes still running exp=all lanes finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
